// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, state encoding, mux codes and control-word type shared by the controller
package multicycle_ctrl_pkg;
  localparam logic [3:0] OP_R = 4'h0, OP_ADDI = 4'h1, OP_LUI = 4'h2, OP_LW = 4'h3, OP_SW = 4'h4;
  localparam logic [3:0] OP_BR = 4'h5, OP_J = 4'h6, OP_JAL = 4'h7, OP_HALT = 4'hF;
  localparam logic [1:0] PC_INC = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10;
  localparam logic [2:0] RWS_ALU = 3'b000, RWS_MEM = 3'b001, RWS_UP = 3'b010, RWS_PC = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMADR, S_MEMRD, S_MEMWR, S_WB, S_BRANCH, S_JUMP, S_HALT
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       write;
    logic       mw;
    logic       lm;
    logic       src_b;
    logic [2:0] alu_op;
    logic       fu;
    logic [2:0] cc;
    logic       rw;
    logic [2:0] rw_src;
    logic       halted;
  } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath signal bundle; master is the controller, slave the datapath
interface multicycle_ctrl_if;
  logic [15:0] ir;
  logic        perform;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        iord;
  logic        write;
  logic        mw;
  logic        lm;
  logic        src_b;
  logic [2:0]  alu_op;
  logic        fu;
  logic [3:0]  op;
  logic [2:0]  cc;
  logic        rw;
  logic [2:0]  rw_src;
  logic        halted;
  logic        mem_timeout;
  modport master (
    input  ir, perform, mem_ready,
    output ir_write, pc_write, pc_src, iord, write, mw, lm, src_b, alu_op, fu, op, cc, rw, rw_src,
           halted, mem_timeout
  );
  modport slave (
    output ir, perform, mem_ready,
    input  ir_write, pc_write, pc_src, iord, write, mw, lm, src_b, alu_op, fu, op, cc, rw, rw_src,
           halted, mem_timeout
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational control-word table from state and instruction fields
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opc,
  input  logic [2:0] cc_fld,
  input  logic [2:0] fn,
  input  logic       perform,
  input  logic       mem_ready,
  output ctrl_t      cw
);
  // Moore word per state; only FETCH strobes follow MemReady and only BRANCH's PCWrite follows Perform
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.write    = 1'b1;
        cw.ir_write = mem_ready;
        cw.pc_write = mem_ready;
        cw.pc_src   = PC_INC;
      end
      S_EXEC: begin
        cw.alu_op = opc == OP_R ? fn : ALU_ADD;
        cw.src_b  = opc == OP_ADDI;
        cw.fu     = 1'b1;
      end
      S_MEMADR: begin
        cw.alu_op = ALU_ADD;
        cw.src_b  = 1'b1;
      end
      S_MEMRD, S_MEMWR: begin
        cw.iord  = 1'b1;
        cw.write = 1'b1;
        cw.mw    = state == S_MEMWR;
      end
      S_WB: begin
        cw.rw     = 1'b1;
        cw.lm     = opc == OP_LW;
        cw.rw_src = opc == OP_LW ? RWS_MEM : opc == OP_LUI ? RWS_UP : RWS_ALU;
      end
      S_BRANCH: begin
        cw.cc       = cc_fld;
        cw.pc_src   = PC_BR;
        cw.pc_write = perform;
      end
      S_JUMP: begin
        cw.pc_src   = PC_JMP;
        cw.pc_write = 1'b1;
        cw.rw       = opc == OP_JAL;
        cw.rw_src   = opc == OP_JAL ? RWS_PC : RWS_ALU;
      end
      S_HALT: cw.halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: cw.halted = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM, memory wait counter and Op register; ILLEGAL_TRAP_EN sends illegal opcodes to TRAP
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 8
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);
  state_t     state;
  logic [7:0] cnt;
  logic [3:0] op;
  logic       mem_st;
  logic       timeout;
  ctrl_t      cw;
  assign mem_st  = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign timeout = mem_st && !bus.mem_ready && cnt == 8'(MEM_WAIT_MAX - 1);
  multicycle_ctrl_decode u_dec (
    .state    (state),
    .opc      (bus.ir[15:12]),
    .cc_fld   (bus.ir[11:9]),
    .fn       (bus.ir[2:0]),
    .perform  (bus.perform),
    .mem_ready(bus.mem_ready),
    .cw       (cw)
  );
  assign bus.ir_write    = cw.ir_write;
  assign bus.pc_write    = cw.pc_write;
  assign bus.pc_src      = cw.pc_src;
  assign bus.iord        = cw.iord;
  assign bus.write       = cw.write;
  assign bus.mw          = cw.mw;
  assign bus.lm          = cw.lm;
  assign bus.src_b       = cw.src_b;
  assign bus.alu_op      = cw.alu_op;
  assign bus.fu          = cw.fu;
  assign bus.cc          = cw.cc;
  assign bus.rw          = cw.rw;
  assign bus.rw_src      = cw.rw_src;
  assign bus.halted      = cw.halted;
  assign bus.op          = op;
  assign bus.mem_timeout = timeout;
  // Sequencer: wait counter only runs while a memory state stalls, so every entry starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      cnt <= mem_st && !bus.mem_ready && !timeout ? cnt + 8'd1 : '0;
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op <= bus.ir[15:12];
          case (bus.ir[15:12])
            OP_R, OP_ADDI: state <= S_EXEC;
            OP_LUI:        state <= S_WB;
            OP_LW, OP_SW:  state <= S_MEMADR;
            OP_BR:         state <= S_BRANCH;
            OP_J, OP_JAL:  state <= S_JUMP;
            OP_HALT:       state <= S_HALT;
`ifdef ILLEGAL_TRAP_EN
            default:       state <= S_TRAP;
`else
            default:       state <= S_FETCH;
`endif
          endcase
        end
        S_EXEC:   state <= S_WB;
        S_MEMADR: state <= bus.ir[15:12] == OP_SW ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state <= S_WB;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
        default:  state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl (honours ILLEGAL_TRAP_EN)
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       wr;
    logic       mw;
    logic       lm;
    logic       srcb;
    logic [2:0] alu;
    logic       fu;
    logic [3:0] op;
    logic [2:0] cc;
    logic       rw;
    logic [2:0] rws;
    logic       hlt;
    logic       tmo;
  } obs_t;
  typedef struct {
    logic  rdy;
    logic  perf;
    obs_t  e;
    string tag;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  item_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] p = 4'h0;
  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.MEM_WAIT_MAX(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t observe();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.iord, bus.write, bus.mw, bus.lm, bus.src_b,
            bus.alu_op, bus.fu, bus.op, bus.cc, bus.rw, bus.rw_src, bus.halted, bus.mem_timeout};
  endfunction
  function automatic obs_t z(input logic [3:0] op);
    obs_t e;
    e = '0;
    e.op = op;
    return e;
  endfunction
  task automatic check(input obs_t exp, input string tag);
    obs_t got;
    got = observe();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic rdy, input logic perf, input obs_t e, input string tag);
    item_t it;
    it.rdy = rdy;
    it.perf = perf;
    it.e = e;
    it.tag = tag;
    q.push_back(it);
  endtask
  task automatic drain();
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      bus.mem_ready = it.rdy;
      bus.perform = it.perf;
      #1;
      check(it.e, it.tag);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check('0, "reset");
    @(negedge clk);
    check('0, "reset_idle");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p = 4'h0;
  endtask
  task automatic instr(input logic [15:0] ir, input int fw, input int mwt, input logic perf);
    obs_t e;
    logic [3:0] o;
    o = ir[15:12];
    bus.ir = ir;
    for (int w = 1; w <= fw; w++) begin
      e = z(p); e.wr = 1'b1; e.tmo = (w % 8 == 0);
      push(1'b0, 1'b0, e, "fetch_wait");
    end
    e = z(p); e.wr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push(1'b1, 1'b0, e, "fetch");
    push(1'b1, 1'b0, z(p), "decode");
    e = z(o);
    case (o)
      4'h0, 4'h1: begin
        e.alu = o == 4'h0 ? ir[2:0] : 3'b000; e.srcb = o == 4'h1; e.fu = 1'b1;
        push(1'b1, 1'b0, e, "exec");
        e = z(o); e.rw = 1'b1;
        push(1'b1, 1'b0, e, "wb_alu");
      end
      4'h2: begin
        e.rw = 1'b1; e.rws = 3'b010;
        push(1'b1, 1'b0, e, "wb_lui");
      end
      4'h3, 4'h4: begin
        e.srcb = 1'b1;
        push(1'b1, 1'b0, e, "memadr");
        e = z(o); e.iord = 1'b1; e.wr = 1'b1; e.mw = o == 4'h4;
        for (int w = 1; w <= mwt; w++) begin
          e.tmo = (w % 8 == 0);
          push(1'b0, 1'b0, e, "mem_wait");
        end
        e.tmo = 1'b0;
        push(1'b1, 1'b0, e, "mem");
        if (o == 4'h3) begin
          e = z(o); e.rw = 1'b1; e.lm = 1'b1; e.rws = 3'b001;
          push(1'b1, 1'b0, e, "wb_lw");
        end
      end
      4'h5: begin
        e.cc = ir[11:9]; e.pcs = 2'b01; e.pcw = perf;
        push(1'b1, perf, e, "branch");
      end
      4'h6, 4'h7: begin
        e.pcs = 2'b10; e.pcw = 1'b1; e.rw = o == 4'h7; e.rws = o == 4'h7 ? 3'b011 : 3'b000;
        push(1'b1, 1'b0, e, "jump");
      end
      4'hF: begin
        e.hlt = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, e, "halt");
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        e.hlt = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, e, "trap");
`endif
      end
    endcase
    drain();
    p = o;
  endtask
  initial begin
    obs_t e;
    bus.ir = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.perform = 1'b0;
    #12;
    check('0, "por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.ir = 16'h3000;
    e = z(4'h0); e.wr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push(1'b1, 1'b0, e, "fetch");
    push(1'b1, 1'b0, z(4'h0), "decode");
    e = z(4'h3); e.srcb = 1'b1;
    push(1'b1, 1'b0, e, "memadr");
    e = z(4'h3); e.iord = 1'b1; e.wr = 1'b1;
    push(1'b0, 1'b0, e, "memrd_wait");
    push(1'b0, 1'b0, e, "memrd_wait");
    drain();
    do_reset();
    instr(16'h0003, 0, 0, 1'b0);
    instr(16'h1005, 17, 0, 1'b0);
    instr(16'h3123, 0, 3, 1'b0);
    instr(16'h4000, 0, 9, 1'b0);
    instr(16'h2ABC, 0, 0, 1'b0);
    instr(16'h5E00, 0, 0, 1'b1);
    instr(16'h5E00, 0, 0, 1'b0);
    instr(16'h5400, 0, 0, 1'b1);
    instr(16'h6123, 0, 0, 1'b0);
    instr(16'h7123, 0, 0, 1'b0);
    instr(16'h9000, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif
    instr(16'h0006, 0, 0, 1'b0);
    instr(16'hF000, 0, 0, 1'b0);
    do_reset();
    instr(16'h0001, 1, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
